control_sequencer: RTL and testbench

//  Multicycle control FSM for the 16-bit accumulator CPU; successor to the fixed control state machine.

---
 rtl/control_pkg.sv | 74 +++++++
 rtl/control_sequencer_if.sv | 26 ++
 rtl/control_opcode_decode.sv | 70 +++++++
 rtl/control_sequencer.sv | 123 ++++++++++++
 tb/tb_control_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// Shared constants for the accumulator CPU control path: state codes seen by
// the datapath control decoder, opcode and source-mode codes, and the
// instruction classes produced by the opcode decoder.
package control_pkg;

  localparam int OPC_W     = 5;
  localparam int MODE_W    = 2;
  localparam int MUL_CNT_W = $clog2(8);

  // State codes are the contract with the datapath control decoder.
  typedef enum logic [4:0] {
    RESET           = 5'd0,
    FETCH_1         = 5'd1,
    FETCH_2         = 5'd2,
    LOAD_JUMP_1     = 5'd3,
    LOAD_JUMP_2     = 5'd4,
    EXECUTE_JUMP    = 5'd5,
    COPY_REGISTER_1 = 5'd6,
    COPY_REGISTER_2 = 5'd7,
    FETCH_IMMEDIATE = 5'd8,
    FETCH_ADDRESS_1 = 5'd9,
    FETCH_ADDRESS_2 = 5'd10,
    FETCH_ADDRESS_3 = 5'd11,
    FETCH_ADDRESS_4 = 5'd12,
    FETCH_MEMORY    = 5'd13,
    STORE_MEMORY    = 5'd14,
    TEMP_FETCH      = 5'd15,
    TEMP_STORE      = 5'd16,
    ALU_OPERATION   = 5'd17,
    STORE_RESULT_1  = 5'd18,
    STORE_RESULT_2  = 5'd19,
    IRQ_SAVE        = 5'd20,
    IRQ_VECTOR      = 5'd21,
    HALT            = 5'd22
  } state_t;

  // Opcodes with dedicated sequences; every other opcode with MSB=0 is ALU class.
  localparam logic [OPC_W-1:0] OPC_NOP      = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_JUMP     = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_LOAD     = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_STORE    = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_MOVE     = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_MULTIPLY = 5'b01000;
  localparam logic [OPC_W-1:0] OPC_RSVD_A   = 5'b01101;
  localparam logic [OPC_W-1:0] OPC_RSVD_B   = 5'b01110;

  localparam logic [MODE_W-1:0] MODE_REG = 2'b00;
  localparam logic [MODE_W-1:0] MODE_IMM = 2'b01;
  localparam logic [MODE_W-1:0] MODE_MEM = 2'b10;
  localparam logic [MODE_W-1:0] MODE_BAD = 2'b11;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_JUMP,
    CLS_LOAD,
    CLS_STORE,
    CLS_MOVE,
    CLS_ALU,
    CLS_MULTIPLY,
    CLS_HALT
  } op_class_t;

  // States that own the memory port and wait for mem_ready.
  function automatic logic is_mem_state(state_t s);
    return s inside {FETCH_1, LOAD_JUMP_1, FETCH_IMMEDIATE, FETCH_ADDRESS_1,
                     FETCH_ADDRESS_3, FETCH_MEMORY, STORE_MEMORY, TEMP_FETCH,
                     TEMP_STORE, IRQ_SAVE};
  endfunction

  function automatic logic is_write_state(state_t s);
    return s inside {STORE_MEMORY, TEMP_STORE, IRQ_SAVE};
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control sequencer bus: instruction register and memory/interrupt inputs in,
// state code and strobes out. master = sequencer side, slave = environment.
interface control_sequencer_if #(
  parameter int INSTR_W = 16,
  parameter int STATE_W = 5
);
  logic [INSTR_W-1:0] instruction;
  logic               mem_ready;
  logic               irq;
  logic [STATE_W-1:0] state;
  logic               mem_req;
  logic               mem_we;
  logic               irq_ack;
  logic               halted;
  logic               illegal;

  modport master (
    input  instruction, mem_ready, irq,
    output state, mem_req, mem_we, irq_ack, halted, illegal
  );

  modport slave (
    output instruction, mem_ready, irq,
    input  state, mem_req, mem_we, irq_ack, halted, illegal
  );
endinterface

// File: rtl/control_opcode_decode.sv
// Combinational instruction classifier: yields the instruction class used by
// later states, the state that follows FETCH_2, and whether the encoding is
// illegal (bad source mode for the opcode).
module control_opcode_decode
  import control_pkg::*;
#(
  parameter int INSTR_W = 16
) (
  input  logic [INSTR_W-1:0] instruction,
  output op_class_t          op_class,
  output state_t             decode_next,
  output logic               decode_illegal
);

  logic [OPC_W-1:0]  opcode;
  logic [MODE_W-1:0] mode;
  logic              unused_operand;

  assign opcode = instruction[INSTR_W-1 -: OPC_W];
  assign mode   = instruction[INSTR_W-OPC_W-1 -: MODE_W];
  // Operand bits belong to the datapath; the sequencer never looks at them.
  assign unused_operand = ^instruction[INSTR_W-OPC_W-MODE_W-1:0];

  // Classify opcode/mode into the post-FETCH_2 state.
  always_comb begin
    // NOTE: every output gets a default first so no path through the
    // block leaves one unassigned, which would infer a latch.
    op_class       = CLS_HALT;
    decode_next    = HALT;
    decode_illegal = 1'b0;
    if (opcode[OPC_W-1] || opcode == OPC_RSVD_A || opcode == OPC_RSVD_B) begin
      // Intentional halt: not an error.
      op_class = CLS_HALT;
    end else begin
      case (opcode)
        OPC_NOP: begin
          op_class    = CLS_NOP;
          decode_next = FETCH_1;
        end
        OPC_JUMP: begin
          op_class    = CLS_JUMP;
          decode_next = LOAD_JUMP_1;
        end
        OPC_LOAD: begin
          op_class = CLS_LOAD;
          case (mode)
            MODE_REG: decode_next = COPY_REGISTER_1;
            MODE_IMM: decode_next = FETCH_IMMEDIATE;
            MODE_MEM: decode_next = FETCH_ADDRESS_1;
            default:  decode_illegal = 1'b1;
          endcase
        end
        OPC_STORE, OPC_MOVE: begin
          op_class = (opcode == OPC_STORE) ? CLS_STORE : CLS_MOVE;
          if (mode == MODE_BAD) decode_illegal = 1'b1;
          else                  decode_next    = FETCH_ADDRESS_1;
        end
        default: begin
          op_class = (opcode == OPC_MULTIPLY) ? CLS_MULTIPLY : CLS_ALU;
          case (mode)
            MODE_REG: decode_next = ALU_OPERATION;
            MODE_IMM: decode_next = FETCH_IMMEDIATE;
            default:  decode_illegal = 1'b1;
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Multicycle control FSM for the 16-bit accumulator CPU. Adds memory wait
// states, level interrupt entry, an illegal-instruction trap, a configurable
// multiply writeback length and interrupt wake-up from HALT.
module control_sequencer
  import control_pkg::*;
#(
  parameter int INSTR_W       = 16,
  parameter int STATE_W       = 5,
  parameter int MUL_WB_CYCLES = 2,
  parameter int IRQ_EN        = 1,
  parameter int HALT_IRQ_WAKE = 1
) (
  input logic                 clock,
  input logic                 reset,
  control_sequencer_if.master bus
);

  localparam bit IRQ_ON   = (IRQ_EN != 0);
  localparam bit WAKE_ON  = (HALT_IRQ_WAKE != 0) && IRQ_ON;
  localparam bit MUL_LONG = (MUL_WB_CYCLES > 1);
  localparam logic [MUL_CNT_W-1:0] MUL_LAST = MUL_CNT_W'(MUL_WB_CYCLES - 2);

  state_t                 state_q, state_d;
  logic                   mask_q;
  logic [MUL_CNT_W-1:0]   mul_cnt_q;
  logic                   illegal_q;
  logic                   set_illegal;
  logic                   irq_take;
  op_class_t              op_class;
  state_t                 decode_next;
  logic                   decode_illegal;

  control_opcode_decode #(.INSTR_W(INSTR_W)) u_decode (
    .instruction    (bus.instruction),
    .op_class       (op_class),
    .decode_next    (decode_next),
    .decode_illegal (decode_illegal)
  );

  assign irq_take = IRQ_ON && bus.irq && !mask_q;

  // Next-state logic; instruction completion is diverted into interrupt entry.
  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    case (state_q)
      RESET:           state_d = FETCH_1;
      FETCH_1:         if (bus.mem_ready) state_d = FETCH_2;
      FETCH_2: begin
        state_d     = decode_next;
        set_illegal = decode_illegal;
      end
      LOAD_JUMP_1:     if (bus.mem_ready) state_d = LOAD_JUMP_2;
      LOAD_JUMP_2:     state_d = EXECUTE_JUMP;
      EXECUTE_JUMP:    state_d = FETCH_1;
      COPY_REGISTER_1: state_d = COPY_REGISTER_2;
      COPY_REGISTER_2: state_d = FETCH_1;
      FETCH_IMMEDIATE:
        if (bus.mem_ready) state_d = (op_class == CLS_LOAD) ? FETCH_1 : ALU_OPERATION;
      FETCH_ADDRESS_1: if (bus.mem_ready) state_d = FETCH_ADDRESS_2;
      FETCH_ADDRESS_2: begin
        case (op_class)
          CLS_LOAD:  state_d = FETCH_MEMORY;
          CLS_STORE: state_d = STORE_MEMORY;
          default:   state_d = TEMP_FETCH;
        endcase
      end
      FETCH_MEMORY,
      STORE_MEMORY,
      TEMP_STORE:      if (bus.mem_ready) state_d = FETCH_1;
      TEMP_FETCH:      if (bus.mem_ready) state_d = FETCH_ADDRESS_3;
      FETCH_ADDRESS_3: if (bus.mem_ready) state_d = FETCH_ADDRESS_4;
      FETCH_ADDRESS_4: state_d = TEMP_STORE;
      ALU_OPERATION:   state_d = STORE_RESULT_1;
      STORE_RESULT_1:
        state_d = (op_class == CLS_MULTIPLY && MUL_LONG) ? STORE_RESULT_2 : FETCH_1;
      STORE_RESULT_2:  if (mul_cnt_q == MUL_LAST) state_d = FETCH_1;
      IRQ_SAVE:        if (bus.mem_ready) state_d = IRQ_VECTOR;
      IRQ_VECTOR:      state_d = FETCH_1;
      HALT:            if (WAKE_ON && bus.irq) state_d = IRQ_SAVE;
      default: begin
        state_d     = HALT;
        set_illegal = 1'b1;
      end
    endcase
    // A FETCH_1 hold is not a completion, and the vector exit must reach the ISR.
    if (state_d == FETCH_1 && state_q != FETCH_1 && state_q != IRQ_VECTOR && irq_take)
      state_d = IRQ_SAVE;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset) state_q <= RESET;
    else        state_q <= state_d;
  end

  // Interrupt mask, multiply writeback counter and sticky illegal flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mask_q    <= 1'b0;
      mul_cnt_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (state_q == IRQ_VECTOR)   mask_q <= 1'b1;
      else if (state_q == FETCH_2) mask_q <= 1'b0;

      if (state_q == STORE_RESULT_1)      mul_cnt_q <= '0;
      else if (state_q == STORE_RESULT_2) mul_cnt_q <= mul_cnt_q + 1'b1;

      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  assign bus.state   = STATE_W'(state_q);
  assign bus.mem_req = is_mem_state(state_q);
  assign bus.mem_we  = is_write_state(state_q);
  assign bus.irq_ack = IRQ_ON && (state_q == IRQ_VECTOR);
  assign bus.halted  = (state_q == HALT);
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer. A generator expands each
// instruction into its expected per-cycle state trace (with random wait
// states and interrupts); the driver applies one cycle of inputs and queues
// the expected outputs; a negedge monitor pops and compares.
module tb_control_sequencer;
  import control_pkg::*;

  typedef struct {
    logic [15:0] instr;
    bit          ready;
    bit          irq;
    state_t      st;
    bit          ill;
  } step_t;

  typedef struct {
    int     dut;
    int     idx;
    state_t st;
    bit     ill;
  } exp_t;

  typedef struct packed {
    logic [4:0] st;
    logic       req;
    logic       we;
    logic       ack;
    logic       hlt;
    logic       ill;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  step_t       plan_q[$];
  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          step_no = 0;
  int          cur_dut = 0;
  int          mul_wb = 4;
  bit          wake = 1'b1;
  bit          m_mask = 1'b0;
  bit          m_ill = 1'b0;
  logic [15:0] last_ins = '0;
  logic [4:0]  alu_ops [8] = '{5'b00101, 5'b00110, 5'b00111, 5'b01001,
                               5'b01010, 5'b01011, 5'b01100, 5'b01111};

  control_sequencer_if #(.INSTR_W(16), .STATE_W(5)) bus_a ();
  control_sequencer_if #(.INSTR_W(16), .STATE_W(5)) bus_b ();

  control_sequencer #(.INSTR_W(16), .STATE_W(5), .MUL_WB_CYCLES(4),
                      .IRQ_EN(1), .HALT_IRQ_WAKE(1)) dut_a (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus_a)
  );

  control_sequencer #(.INSTR_W(16), .STATE_W(5), .MUL_WB_CYCLES(1),
                      .IRQ_EN(1), .HALT_IRQ_WAKE(0)) dut_b (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Strobe expectations straight from the list of memory-owning states.
  function automatic bit exp_req(state_t s);
    return s inside {FETCH_1, LOAD_JUMP_1, FETCH_IMMEDIATE, FETCH_ADDRESS_1,
                     FETCH_ADDRESS_3, FETCH_MEMORY, STORE_MEMORY, TEMP_FETCH,
                     TEMP_STORE, IRQ_SAVE};
  endfunction

  function automatic bit exp_we(state_t s);
    return s inside {STORE_MEMORY, TEMP_STORE, IRQ_SAVE};
  endfunction

  function automatic obs_t sample(input int dut);
    if (dut == 0)
      return {bus_a.state, bus_a.mem_req, bus_a.mem_we, bus_a.irq_ack, bus_a.halted, bus_a.illegal};
    return {bus_b.state, bus_b.mem_req, bus_b.mem_we, bus_b.irq_ack, bus_b.halted, bus_b.illegal};
  endfunction

  function automatic int rnd_wait();
    return int'($urandom_range(0, 2));
  endfunction

  // ---------------- trace generator (reference model) ----------------
  task automatic add_step(input state_t st, input logic [15:0] ins, input bit irq, input bit ready);
    step_t s;
    s.instr = ins;
    s.ready = ready;
    s.irq   = irq;
    s.st    = st;
    s.ill   = m_ill;
    plan_q.push_back(s);
  endtask

  task automatic plain_step(input state_t st, input logic [15:0] ins, input bit irq);
    add_step(st, ins, irq, 1'($urandom));
  endtask

  task automatic mem_step(input state_t st, input logic [15:0] ins, input bit irq, input int waits);
    for (int i = 0; i < waits; i++) add_step(st, ins, irq, 1'b0);
    add_step(st, ins, irq, 1'b1);
  endtask

  // Instruction completed: enter the interrupt if requested and not masked.
  task automatic finish_instr(input bit irq, input bit mask_now, input logic [15:0] ins);
    if (irq && !mask_now) begin
      mem_step(IRQ_SAVE, ins, irq, rnd_wait());
      plain_step(IRQ_VECTOR, ins, irq);
      m_mask = 1'b1;
    end
  endtask

  task automatic reset_trace(input bit irq);
    m_mask = 1'b0;
    m_ill  = 1'b0;
    last_ins = 16'($urandom);
    plain_step(RESET, last_ins, irq);
    finish_instr(irq, 1'b0, last_ins);
  endtask

  task automatic run_instr(input logic [4:0] opc, input logic [1:0] mode, input bit irq, input int imm_wait);
    logic [15:0] ins;
    bit          mask_dec;
    bit          fin_mask;
    bit          bad;
    int          fi_wait;
    ins      = {opc, mode, 9'($urandom)};
    last_ins = ins;
    fi_wait  = (imm_wait < 0) ? rnd_wait() : imm_wait;
    bad      = 1'b0;
    fin_mask = 1'b0;
    mem_step(FETCH_1, ins, irq, rnd_wait());
    plain_step(FETCH_2, ins, irq);
    mask_dec = m_mask;
    m_mask   = 1'b0;
    if (opc[4] || opc == 5'b01101 || opc == 5'b01110) return;
    case (opc)
      OPC_NOP: fin_mask = mask_dec;
      OPC_JUMP: begin
        mem_step(LOAD_JUMP_1, ins, irq, rnd_wait());
        plain_step(LOAD_JUMP_2, ins, irq);
        plain_step(EXECUTE_JUMP, ins, irq);
      end
      OPC_LOAD: begin
        if (mode == 2'b00) begin
          plain_step(COPY_REGISTER_1, ins, irq);
          plain_step(COPY_REGISTER_2, ins, irq);
        end else if (mode == 2'b01) begin
          mem_step(FETCH_IMMEDIATE, ins, irq, fi_wait);
        end else if (mode == 2'b10) begin
          mem_step(FETCH_ADDRESS_1, ins, irq, rnd_wait());
          plain_step(FETCH_ADDRESS_2, ins, irq);
          mem_step(FETCH_MEMORY, ins, irq, rnd_wait());
        end else bad = 1'b1;
      end
      OPC_STORE, OPC_MOVE: begin
        if (mode == 2'b11) bad = 1'b1;
        else begin
          mem_step(FETCH_ADDRESS_1, ins, irq, rnd_wait());
          plain_step(FETCH_ADDRESS_2, ins, irq);
          if (opc == OPC_STORE) mem_step(STORE_MEMORY, ins, irq, rnd_wait());
          else begin
            mem_step(TEMP_FETCH, ins, irq, rnd_wait());
            mem_step(FETCH_ADDRESS_3, ins, irq, rnd_wait());
            plain_step(FETCH_ADDRESS_4, ins, irq);
            mem_step(TEMP_STORE, ins, irq, rnd_wait());
          end
        end
      end
      default: begin
        if (mode[1]) bad = 1'b1;
        else begin
          if (mode == 2'b01) mem_step(FETCH_IMMEDIATE, ins, irq, fi_wait);
          plain_step(ALU_OPERATION, ins, irq);
          plain_step(STORE_RESULT_1, ins, irq);
          if (opc == OPC_MULTIPLY)
            for (int i = 1; i < mul_wb; i++) plain_step(STORE_RESULT_2, ins, irq);
        end
      end
    endcase
    if (bad) m_ill = 1'b1;
    else     finish_instr(irq, fin_mask, ins);
  endtask

  // Cycles spent in HALT: quiet ones, then ones with irq high.
  task automatic halt_trace(input int n_quiet, input int n_irq);
    for (int i = 0; i < n_quiet; i++) plain_step(HALT, last_ins, 1'b0);
    if (n_irq > 0) begin
      if (wake) begin
        plain_step(HALT, last_ins, 1'b1);
        mem_step(IRQ_SAVE, last_ins, 1'b1, rnd_wait());
        plain_step(IRQ_VECTOR, last_ins, 1'b1);
        m_mask = 1'b1;
      end else begin
        for (int i = 0; i < n_irq; i++) plain_step(HALT, last_ins, 1'b1);
      end
    end
  endtask

  task automatic random_instr();
    int          k;
    logic [4:0]  opc;
    logic [1:0]  mode;
    k = int'($urandom_range(0, 6));
    case (k)
      0:       opc = OPC_NOP;
      1:       opc = OPC_JUMP;
      2:       opc = OPC_LOAD;
      3:       opc = OPC_STORE;
      4:       opc = OPC_MOVE;
      5:       opc = OPC_MULTIPLY;
      default: opc = alu_ops[$urandom_range(0, 7)];
    endcase
    if (k <= 1)      mode = 2'($urandom_range(0, 3));
    else if (k <= 4) mode = 2'($urandom_range(0, 2));
    else             mode = 2'($urandom_range(0, 1));
    run_instr(opc, mode, $urandom_range(0, 3) == 0, -1);
  endtask

  // ---------------- driver / monitor ----------------
  task automatic drive(input logic [15:0] ins, input bit ready, input bit irq);
    bus_a.instruction = ins;
    bus_a.mem_ready   = ready;
    bus_a.irq         = irq;
    bus_b.instruction = ins;
    bus_b.mem_ready   = ready;
    bus_b.irq         = irq;
  endtask

  task automatic run_plan();
    step_t s;
    exp_t  e;
    while (plan_q.size() > 0) begin
      s = plan_q.pop_front();
      drive(s.instr, s.ready, s.irq);
      e.dut = cur_dut;
      e.idx = step_no;
      e.st  = s.st;
      e.ill = s.ill;
      exp_q.push_back(e);
      step_no++;
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    obs_t o;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = sample(e.dut);
      check($sformatf("state@%0d", e.idx), 32'(o.st), 32'(e.st));
      check($sformatf("mem_req@%0d", e.idx), 32'(o.req), 32'(exp_req(e.st)));
      check($sformatf("mem_we@%0d", e.idx), 32'(o.we), 32'(exp_we(e.st)));
      check($sformatf("irq_ack@%0d", e.idx), 32'(o.ack), 32'(e.st == IRQ_VECTOR));
      check($sformatf("halted@%0d", e.idx), 32'(o.hlt), 32'(e.st == HALT));
      check($sformatf("illegal@%0d", e.idx), 32'(o.ill), 32'(e.ill));
    end
  end

  // Assert reset between edges, check it acts at once, release mid-cycle.
  task automatic apply_reset(input string tag);
    obs_t o;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    o = sample(cur_dut);
    check({tag, "_async_state"}, 32'(o.st), 32'(RESET));
    check({tag, "_async_strobes"}, 32'({o.req, o.we, o.ack, o.hlt, o.ill}), 32'(0));
    @(posedge clk);
    #1;
    o = sample(cur_dut);
    check({tag, "_held_state"}, 32'(o.st), 32'(RESET));
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    drive('0, 1'b0, 1'b0);

    // Configuration A: MUL_WB_CYCLES=4, HALT_IRQ_WAKE=1.
    cur_dut = 0;
    mul_wb  = 4;
    wake    = 1'b1;
    reset_trace(1'b0);
    run_instr(OPC_LOAD, MODE_IMM, 1'b0, 3);
    run_instr(OPC_MULTIPLY, MODE_REG, 1'b0, -1);
    run_instr(OPC_MOVE, MODE_MEM, 1'b1, -1);
    run_instr(OPC_NOP, MODE_REG, 1'b1, -1);
    run_instr(OPC_JUMP, MODE_REG, 1'b1, -1);
    repeat (40) random_instr();
    run_instr(OPC_LOAD, MODE_BAD, 1'b0, -1);
    halt_trace(4, 1);
    run_instr(OPC_STORE, MODE_REG, 1'b0, -1);
    apply_reset("reset_a");
    run_plan();

    // Configuration B: MUL_WB_CYCLES=1, HALT_IRQ_WAKE=0.
    cur_dut = 1;
    mul_wb  = 1;
    wake    = 1'b0;
    reset_trace(1'b1);
    run_instr(OPC_MULTIPLY, MODE_IMM, 1'b0, -1);
    repeat (30) random_instr();
    run_instr(OPC_RSVD_A, 2'($urandom), 1'b0, -1);
    halt_trace(3, 10);
    apply_reset("reset_b");
    run_plan();

    apply_reset("reset_end");
    #20;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
